// File: rtl/pixel_framebuffer.sv
// Pixel-plot receiver with an on-chip frame memory and a valid/ready raster
// reader that streams the frame back out in row-major order.
module pixel_framebuffer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int COLOR_BITS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  plot,
  input  logic [7:0]            x_in,
  input  logic [6:0]            y_in,
  input  logic [COLOR_BITS-1:0] color_in,
  output logic                  clip_err,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_x,
  output logic [6:0]            out_y,
  output logic [COLOR_BITS-1:0] out_color,
  output logic                  scan_done
);

  localparam int         DEPTH  = WIDTH * HEIGHT;
  localparam logic [7:0] X_LIM  = 8'(WIDTH);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LIM  = 7'(HEIGHT);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [7:0]              sx;
  logic [6:0]              sy;
  logic [COLOR_BITS-1:0]   mem [DEPTH];
  logic                    in_range;
  logic                    wr_en;
  logic [14:0]             wr_addr;
  logic [14:0]             rd_addr;
  logic                    last_pix;

  assign in_range = (x_in < X_LIM) && (y_in < Y_LIM);
  assign wr_en    = plot && in_range;
  assign wr_addr  = 15'(y_in) * 15'(WIDTH) + 15'(x_in);
  assign rd_addr  = 15'(sy) * 15'(WIDTH) + 15'(sx);
  assign last_pix = (sx == X_LAST) && (sy == Y_LAST);

  // Frame memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= color_in;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (scan_start) state_next = FETCH;
        else            state_next = IDLE;
      end
      FETCH: begin
        state_next = PRESENT;
      end
      PRESENT: begin
        if (out_ready) state_next = last_pix ? DONE : FETCH;
        else           state_next = PRESENT;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scan pointer: cleared on accepted scan_start, advanced on each handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sx <= 8'd0;
      sy <= 7'd0;
    end else if (state == IDLE && scan_start) begin
      sx <= 8'd0;
      sy <= 7'd0;
    end else if (state == PRESENT && out_ready && !last_pix) begin
      if (sx == X_LAST) begin
        sx <= 8'd0;
        sy <= sy + 7'd1;
      end else begin
        sx <= sx + 8'd1;
      end
    end
  end

  // Read port: the FETCH-cycle read lands directly in the presented pixel,
  // so a same-cycle write to that address still shows the old colour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_x     <= 8'd0;
      out_y     <= 7'd0;
      out_color <= '0;
    end else if (state == FETCH) begin
      out_x     <= sx;
      out_y     <= sy;
      out_color <= mem[rd_addr];
    end
  end

  // Status outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clip_err  <= 1'b0;
      scan_busy <= 1'b0;
      out_valid <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      clip_err  <= plot && !in_range;
      scan_busy <= (state_next == FETCH) || (state_next == PRESENT);
      out_valid <= (state_next == PRESENT);
      scan_done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Self-checking bench for pixel_framebuffer: table-driven plot vectors plus a
// scoreboard of expected raster pixels checked on every accepted handshake.
module tb_pixel_framebuffer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       resetn;
  logic       plot;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] color_in;
  logic       clip_err;
  logic       scan_start;
  logic       scan_busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_color;
  logic       scan_done;

  pixel_framebuffer #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(3)) dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x_in(x_in), .y_in(y_in),
    .color_in(color_in), .clip_err(clip_err), .scan_start(scan_start),
    .scan_busy(scan_busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_color(out_color), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] x; logic [6:0] y; logic [2:0] c; logic clip; } vec_t;
  typedef struct { logic [7:0] x; logic [6:0] y; logic [2:0] c; bit known; } pix_t;

  logic [2:0] mdl   [N];
  bit         known [N];
  pix_t       exp_q [$];
  pix_t       mon_p;
  vec_t       vecs  [10];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected pixel per accepted handshake.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_pixel: got (%0d,%0d), expected none", out_x, out_y);
      end else begin
        mon_p = exp_q.pop_front();
        chk("pix_x", out_x, mon_p.x);
        chk("pix_y", out_y, mon_p.y);
        if (mon_p.known) chk("pix_color", out_color, mon_p.c);
      end
    end
    if (resetn && scan_done) begin
      done_cnt++;
      chk("queue_empty_at_done", exp_q.size(), 0);
    end
  end

  task automatic do_plot(input int x, input int y, input logic [2:0] c);
    plot = 1'b1; x_in = 8'(x); y_in = 7'(y); color_in = c;
    @(posedge clk); #1;
    plot = 1'b0;
    if (x < W && y < H) begin
      mdl[y * W + x]   = c;
      known[y * W + x] = 1'b1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b1;
  endtask

  task automatic start_scan();
    pix_t p;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        p.x = 8'(xx); p.y = 7'(yy); p.c = mdl[yy * W + xx]; p.known = known[yy * W + xx];
        exp_q.push_back(p);
      end
    end
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    chk("start_busy", scan_busy, 1);
    chk("start_fetch_not_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("first_valid_latency", out_valid, 1);
    chk("first_x", out_x, 0);
    chk("first_y", out_y, 0);
  endtask

  task automatic wait_pix(input string name, input int x, input int y, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid && out_x == 8'(x) && out_y == 7'(y)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int rows [5];
    rows = '{0, 1, 5, 20, 119};
    vecs[0] = '{8'd0,   7'd0,   3'b101, 1'b0};
    vecs[1] = '{8'd159, 7'd0,   3'b010, 1'b0};
    vecs[2] = '{8'd0,   7'd1,   3'b111, 1'b0};
    vecs[3] = '{8'd159, 7'd119, 3'b001, 1'b0};
    vecs[4] = '{8'd160, 7'd5,   3'b111, 1'b1};
    vecs[5] = '{8'd5,   7'd120, 3'b111, 1'b1};
    vecs[6] = '{8'd255, 7'd127, 3'b011, 1'b1};
    vecs[7] = '{8'd159, 7'd120, 3'b110, 1'b1};
    vecs[8] = '{8'd160, 7'd0,   3'b110, 1'b1};
    vecs[9] = '{8'd10,  7'd20,  3'b100, 1'b0};

    resetn = 1'b0; plot = 1'b0; x_in = 8'd0; y_in = 7'd0; color_in = 3'd0;
    scan_start = 1'b0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_scan_busy", scan_busy, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_clip_err", clip_err, 0);
    chk("rst_out_xyc", {out_x, out_y, out_color}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Known background on a few rows so the scan can check their colours.
    foreach (rows[r]) begin
      for (int xx = 0; xx < W; xx++) do_plot(xx, rows[r], 3'((xx + rows[r]) % 8));
    end

    foreach (vecs[i]) begin
      do_plot(int'(vecs[i].x), int'(vecs[i].y), vecs[i].c);
      chk($sformatf("clip_vec%0d", i), clip_err, vecs[i].clip);
      @(posedge clk); #1;
      chk($sformatf("clip_drop_vec%0d", i), clip_err, 0);
    end

    // Full scan with backpressure at (3,0) and an ignored mid-scan scan_start.
    done_cnt = 0;
    start_scan();
    wait_pix("reach_3_0", 3, 0, 50);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      scan_start = (i == 2);
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_xy", {out_x, out_y}, {8'd3, 7'd0});
      chk("bp_color", out_color, mdl[3]);
    end
    scan_start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("after_bp_xy", {out_x, out_y}, {8'd4, 7'd0});
    for (int i = 0; i < 40000 && done_cnt == 0; i++) begin @(posedge clk); #1; end
    repeat (20) begin @(posedge clk); #1; end
    chk("single_scan_done", done_cnt, 1);
    chk("idle_busy", scan_busy, 0);
    chk("all_pixels_seen", exp_q.size(), 0);

    // Reset in the middle of a scan aborts it without scan_done.
    done_cnt = 0;
    start_scan();
    wait_pix("reach_50_20", 50, 20, 8000);
    do_reset();
    exp_q.delete();
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", scan_busy, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, 0);

    // Write colliding with the FETCH of the same pixel returns the old colour.
    start_scan();
    wait_pix("reach_6_0", 6, 0, 50);
    @(posedge clk); #1;
    chk("collide_in_fetch", out_valid, 0);
    do_plot(7, 0, 3'b110);
    chk("collide_old_color", out_color, 3'b111);
    wait_pix("reach_8_0", 8, 0, 20);
    do_reset();
    exp_q.delete();

    start_scan();
    wait_pix("rescan_7_0", 7, 0, 50);
    chk("rescan_new_color", out_color, 3'b110);
    do_reset();
    exp_q.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
